// File: rtl/harris_stream_controller.sv
// Frame sequencer for a Harris pipeline with a single input stream and a single output stream.
// Each frame runs CONFIG -> FLUSH -> RUN. The block counts pixels in each direction,
// detects the end of the frame, and latches the first protocol fault it sees.
module harris_stream_controller #(
    parameter int IMG_PIXELS    = 4096,
    parameter int OUT_PIXELS    = 3364,
    parameter int CONFIG_CYCLES = 410,
    parameter int TIMEOUT       = 4096,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic             flush,
    input  logic             src_valid,
    input  logic [15:0]      src_data,
    output logic             src_ready,
    input  logic             dut_read_en,
    output logic [15:0]      dut_read_data,
    input  logic             dut_write_valid,
    input  logic [15:0]      dut_write_data,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_FLUSH,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] IMG_LIM      = CNT_W'(IMG_PIXELS);
    localparam logic [CNT_W-1:0] OUT_LAST_IDX = CNT_W'(OUT_PIXELS - 1);
    localparam logic [CNT_W-1:0] CFG_LAST     = CNT_W'(CONFIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] in_count_q, in_count_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      out_data_q, out_data_d;

    logic run;
    logic rd_run;
    logic wr_run;

    // Strobes are qualified by RUN so that activity in other states is ignored.
    assign run    = (state_q == S_RUN);
    assign rd_run = dut_read_en & run;
    assign wr_run = dut_write_valid & run;

    // The read path is combinational, so the pipeline sees the pixel in the same cycle.
    assign src_ready     = rd_run;
    assign dut_read_data = run ? src_data : '0;

    assign busy      = (state_q == S_CONFIG) || (state_q == S_FLUSH) || run;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign flush     = (state_q == S_FLUSH);
    assign err_code  = err_code_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign in_count  = in_count_q;
    assign out_count = out_count_q;

    // Next-state logic: frame sequencing, saturating counters, fault priority.
    always_comb begin
        state_d     = state_q;
        cfg_cnt_d   = cfg_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        err_code_d  = err_code_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = (CONFIG_CYCLES == 0) ? S_FLUSH : S_CONFIG;
                    cfg_cnt_d   = '0;
                    idle_cnt_d  = '0;
                    in_count_d  = '0;
                    out_count_d = '0;
                    err_code_d  = 2'b00;
                end
            end
            S_CONFIG: begin
                if (cfg_cnt_q >= CFG_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (rd_run && (in_count_q != CNT_MAX)) begin
                    in_count_d = in_count_q + 1'b1;
                end
                if (wr_run) begin
                    if (out_count_q != CNT_MAX) begin
                        out_count_d = out_count_q + 1'b1;
                    end
                    out_valid_d = 1'b1;
                    out_data_d  = dut_write_data;
                    out_last_d  = (out_count_q == OUT_LAST_IDX);
                end
                if (rd_run || wr_run) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // A fault outranks completion even when it lands on the final write.
                if (rd_run && !src_valid) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'b01;
                end else if (rd_run && (in_count_q == IMG_LIM)) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'b10;
                end else if (!rd_run && !wr_run && (idle_cnt_q >= TO_LAST)) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'b11;
                end else if (wr_run && (out_count_q == OUT_LAST_IDX)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            err_code_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            err_code_q  <= err_code_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_harris_stream_controller.sv
// Directed bench for harris_stream_controller, using a small frame geometry.
module tb_harris_stream_controller;

    localparam int CFG  = 4;
    localparam int IMG  = 16;
    localparam int OUTP = 4;
    localparam int TO   = 8;
    localparam int W    = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, error, flush;
    logic [1:0]   err_code;
    logic         src_valid = 1'b0;
    logic [15:0]  src_data = '0;
    logic         src_ready;
    logic         dut_read_en = 1'b0;
    logic [15:0]  dut_read_data;
    logic         dut_write_valid = 1'b0;
    logic [15:0]  dut_write_data = '0;
    logic         out_valid;
    logic [15:0]  out_data;
    logic         out_last;
    logic [W-1:0] in_count, out_count;

    int total = 0;
    int bad   = 0;

    harris_stream_controller #(
        .IMG_PIXELS(IMG), .OUT_PIXELS(OUTP), .CONFIG_CYCLES(CFG), .TIMEOUT(TO), .CNT_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .flush(flush),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .dut_read_en(dut_read_en), .dut_read_data(dut_read_data),
        .dut_write_valid(dut_write_valid), .dut_write_data(dut_write_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge, where the next cycle begins.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Pulse start so that it is captured at the next edge; returns in cycle 1.
    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] d, input logic v);
        dut_read_en = 1'b1;
        src_valid   = v;
        src_data    = d;
        tick();
        dut_read_en = 1'b0;
        src_valid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1);
    end

    initial begin
        // Reset state, plus strobes applied while idle
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        dut_read_en = 1'b1; dut_write_valid = 1'b1; src_data = 16'habcd; src_valid = 1'b1;
        sample();
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_error", error, 0);     chk("rst_flush", flush, 0);
        chk("rst_oval", out_valid, 0);  chk("rst_olast", out_last, 0);
        chk("rst_ecode", err_code, 0);  chk("rst_odata", out_data, 0);
        chk("rst_incnt", in_count, 0);  chk("rst_outcnt", out_count, 0);
        chk("idle_srdy", src_ready, 0); chk("idle_rdata", dut_read_data, 0);
        tick();
        sample();
        chk("idle_oval", out_valid, 0); chk("idle_incnt", in_count, 0);
        dut_read_en = 1'b0; dut_write_valid = 1'b0;
        $display("txn reset: in=%0d out=%0d", in_count, out_count);

        // Nominal frame; strobes held through CONFIG and FLUSH must be ignored
        tick();
        start_frame();
        dut_read_en = 1'b1; dut_write_valid = 1'b1; src_valid = 1'b1; dut_write_data = 16'h1234;
        for (int c = 1; c <= CFG; c++) begin
            sample();
            chk($sformatf("cfg%0d_busy", c), busy, 1);
            chk($sformatf("cfg%0d_flush", c), flush, 0);
            chk($sformatf("cfg%0d_srdy", c), src_ready, 0);
            tick();
        end
        sample();
        chk("flush_hi", flush, 1);   chk("flush_incnt", in_count, 0);
        chk("flush_outcnt", out_count, 0); chk("flush_oval", out_valid, 0);
        tick();
        dut_write_valid = 1'b0;
        for (int i = 0; i < IMG; i++) begin
            dut_read_en = 1'b1; src_valid = 1'b1; src_data = 16'h0100 + 16'(i);
            start = (i == 0);
            sample();
            if (i == 0) begin
                chk("run_flush_lo", flush, 0);
                chk("run_oval_from_flush", out_valid, 0);
            end
            chk($sformatf("rd%0d_srdy", i), src_ready, 1);
            chk($sformatf("rd%0d_rdata", i), dut_read_data, 32'h0100 + i);
            chk($sformatf("rd%0d_incnt", i), in_count, i);
            tick();
            start = 1'b0;
        end
        dut_read_en = 1'b0; src_valid = 1'b0;
        for (int j = 0; j < OUTP; j++) begin
            dut_write_valid = 1'b1; dut_write_data = 16'h0500 + 16'(j);
            tick();
            dut_write_valid = 1'b0;
            sample();
            chk($sformatf("wr%0d_oval", j), out_valid, 1);
            chk($sformatf("wr%0d_odata", j), out_data, 32'h0500 + j);
            chk($sformatf("wr%0d_olast", j), out_last, (j == OUTP - 1) ? 1 : 0);
            chk($sformatf("wr%0d_outcnt", j), out_count, j + 1);
            if (j < OUTP - 1) begin
                chk($sformatf("wr%0d_busy", j), busy, 1);
                tick();
            end
        end
        chk("nom_done", done, 1);     chk("nom_busy", busy, 0);
        chk("nom_ecode", err_code, 0); chk("nom_incnt", in_count, IMG);
        tick();
        sample();
        chk("nom_oval_drop", out_valid, 0); chk("nom_olast_drop", out_last, 0);
        chk("nom_done_hold", done, 1);
        $display("txn nominal: in=%0d out=%0d done=%0d", in_count, out_count, done);

        // Restart from DONE, then an underrun on read 7
        tick();
        start_frame();
        sample();
        chk("restart_incnt", in_count, 0); chk("restart_outcnt", out_count, 0);
        chk("restart_done", done, 0);      chk("restart_busy", busy, 1);
        repeat (CFG + 1) tick();
        for (int i = 1; i <= 7; i++) begin
            dut_read_en = 1'b1; src_valid = (i != 7); src_data = 16'(i);
            if (i == 7) begin
                sample();
                chk("udr_srdy", src_ready, 1);
                chk("udr_err_pre", error, 0);
            end
            tick();
        end
        dut_read_en = 1'b0; src_valid = 1'b0;
        sample();
        chk("udr_error", error, 1); chk("udr_ecode", err_code, 1);
        chk("udr_incnt", in_count, 7); chk("udr_busy", busy, 0);
        $display("txn underrun: in=%0d code=%0d", in_count, err_code);

        // Restart from ERROR, then an over-read on read 17
        tick();
        start_frame();
        repeat (CFG + 1) tick();
        for (int i = 1; i <= IMG + 1; i++) begin
            if (i == IMG + 1) begin
                dut_read_en = 1'b1; src_valid = 1'b1;
                sample();
                chk("ovr_err_pre", error, 0);
                chk("ovr_incnt_pre", in_count, IMG);
                tick();
                dut_read_en = 1'b0; src_valid = 1'b0;
            end else begin
                do_read(16'(i), 1'b1);
            end
        end
        sample();
        chk("ovr_error", error, 1); chk("ovr_ecode", err_code, 2);
        chk("ovr_incnt", in_count, IMG + 1);
        $display("txn overread: in=%0d code=%0d", in_count, err_code);

        // Timeout: 3 reads, then silence; error must appear 9 cycles after the last read
        tick();
        start_frame();
        repeat (CFG + 1) tick();
        for (int i = 0; i < 3; i++) do_read(16'(i), 1'b1);
        for (int k = 1; k <= 9; k++) begin
            sample();
            chk($sformatf("to_err_k%0d", k), error, (k == 9) ? 1 : 0);
            if (k == 9) begin
                chk("to_ecode", err_code, 3);
                chk("to_incnt", in_count, 3);
            end
            tick();
        end
        $display("txn timeout: in=%0d code=%0d", in_count, err_code);

        // Reset mid-RUN with in_count=10, then a clean frame
        start_frame();
        repeat (CFG + 1) tick();
        for (int i = 0; i < 10; i++) do_read(16'(i), 1'b1);
        sample();
        chk("mid_incnt", in_count, 10);
        rst_n = 1'b0; dut_write_valid = 1'b1; dut_write_data = 16'hbeef;
        tick();
        rst_n = 1'b1; dut_write_valid = 1'b0;
        sample();
        chk("mrst_busy", busy, 0);     chk("mrst_incnt", in_count, 0);
        chk("mrst_oval", out_valid, 0); chk("mrst_odata", out_data, 0);
        chk("mrst_error", error, 0);   chk("mrst_done", done, 0);
        $display("txn midreset: in=%0d busy=%0d", in_count, busy);
        tick();
        start_frame();
        repeat (CFG + 1) tick();
        for (int i = 0; i < IMG; i++) do_read(16'(i), 1'b1);
        for (int j = 0; j < OUTP; j++) begin
            dut_write_valid = 1'b1; dut_write_data = 16'h0a00 + 16'(j);
            tick();
        end
        dut_write_valid = 1'b0;
        sample();
        chk("clean_done", done, 1);      chk("clean_ecode", err_code, 0);
        chk("clean_incnt", in_count, IMG); chk("clean_outcnt", out_count, OUTP);
        chk("clean_olast", out_last, 1); chk("clean_odata", out_data, 32'h0a03);
        $display("txn clean: in=%0d out=%0d done=%0d", in_count, out_count, done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/harris_stream_controller.md
# harris_stream_controller

Run-time sequencer for a clockwork-generated Harris pipeline with one 16-bit input stream and one 16-bit output stream. Sequences each frame through a configuration wait, a one-cycle flush and a streaming run. Sits between an upstream pixel source and the pipeline's self-scheduled read port, and between the pipeline's write port and the downstream sink. Counts pixels, detects frame completion, and flags protocol faults so power and functional runs terminate deterministically.

## Interface
- IMG_PIXELS, 4096: input pixels per frame (padded 64x64).
- OUT_PIXELS, 3364: output pixels per frame (58x58).
- CONFIG_CYCLES, 410: wait cycles between start and flush.
- TIMEOUT, 4096: maximum consecutive RUN cycles with neither a read nor a write.
- CNT_W, 16: counter width; must hold the largest of IMG_PIXELS, OUT_PIXELS, CONFIG_CYCLES and TIMEOUT.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  frame start pulse.
- busy  out  1  high in CONFIG, FLUSH and RUN.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- err_code  out  2  fault code: 01 underrun, 10 over-read, 11 timeout, 00 none.
- flush  out  1  pipeline flush.
- src_valid  in  1  upstream pixel available.
- src_data  in  16  upstream pixel.
- src_ready  out  1  pops an upstream pixel.
- dut_read_en  in  1  pipeline read request.
- dut_read_data  out  16  pixel delivered to the pipeline.
- dut_write_valid  in  1  pipeline output strobe.
- dut_write_data  in  16  pipeline output pixel.
- out_valid  out  1  downstream strobe; no backpressure.
- out_data  out  16  downstream pixel.
- out_last  out  1  marks the final output pixel of a frame.
- in_count  out  CNT_W  pixels read in the current frame.
- out_count  out  CNT_W  pixels written in the current frame.

## Operation
- States: IDLE, CONFIG, FLUSH, RUN, DONE, ERROR. Reset enters IDLE.
- IDLE, DONE or ERROR, start=1: go to CONFIG. Clear both pixel counters, the config counter, the idle counter, err_code and out_last.
- start is ignored in CONFIG, FLUSH and RUN.
- CONFIG: count cycles. After CONFIG_CYCLES cycles, go to FLUSH. CONFIG_CYCLES=0 goes directly to FLUSH.
- FLUSH: flush=1 for exactly one cycle, then go to RUN.
- RUN, read path (combinational):
  - src_ready = dut_read_en & (state==RUN).
  - dut_read_data = src_data when state==RUN, otherwise 0.
  - Each cycle with dut_read_en=1 increments in_count.
- RUN, write path:
  - Each cycle with dut_write_valid=1 increments out_count.
  - The pixel is registered to out_data with out_valid.
  - out_last=1 on the pixel that makes out_count equal OUT_PIXELS.
- RUN faults, checked in this priority order:
  - dut_read_en & !src_valid: ERROR, code 01.
  - dut_read_en when in_count==IMG_PIXELS: ERROR, code 10.
  - Idle counter reaches TIMEOUT: ERROR, code 11.
- Idle counter: increments on RUN cycles with neither dut_read_en nor dut_write_valid. Resets to 0 on any read or write.
- Final write accepted with no fault in the same cycle: go to DONE.
- A read and a write in the same cycle are both counted.
- A fault in the same cycle as the final write: ERROR wins.
- dut_read_en and dut_write_valid are ignored outside RUN: no counting, no pop, no out_valid.
- A strobe that causes an error is still counted and forwarded in that cycle.
- Counters saturate; they never wrap.
- DONE and ERROR hold counters and err_code until the next start or reset.

## Timing
- Reset values:
  - state IDLE.
  - busy, done, error, flush, out_valid, out_last: 0.
  - err_code 00.
  - out_data 0, in_count 0, out_count 0.
  - src_ready and dut_read_data are 0 in IDLE.
- rst_n=0 mid-frame returns to IDLE on that edge and drops all outputs to reset values on the next cycle.
- Cycle sequence:
  - start sampled at edge 0.
  - busy=1 from cycle 1.
  - flush=1 in cycle CONFIG_CYCLES+1.
  - RUN from cycle CONFIG_CYCLES+2.
- Read path has zero latency: src_ready and dut_read_data follow dut_read_en and src_data in the same cycle.
- Write path has one-cycle latency: out_valid, out_data and out_last appear the cycle after dut_write_valid.
- done, error and err_code are registered: they assert the cycle after the terminating event.
- in_count and out_count are registered and reflect strobes through the previous cycle.

## Test plan
- Nominal frame, CONFIG_CYCLES=4, IMG_PIXELS=16, OUT_PIXELS=4, src_valid=1, 16 reads then 4 writes -> flush high only in cycle 5; in_count=16, out_count=4; out_last with the 4th out_valid; done=1, err_code=00.
- Underrun: src_valid=0 while dut_read_en=1 at read 7 -> error=1, err_code=01, in_count=7, src_ready high that cycle.
- Over-read: 17th read with IMG_PIXELS=16 -> err_code=10.
- Timeout, TIMEOUT=8: stop all strobes after 3 reads -> error exactly 9 cycles after the last read, err_code=11.
- Boundary cases:
  - Strobes in CONFIG are ignored; counters stay 0 and out_valid=0.
  - start during RUN has no effect.
  - start from DONE restarts the frame with counters cleared.
- Reset mid-RUN with in_count=10 -> next cycle IDLE, all outputs 0; a new start completes a clean frame.
